// File: rtl/gfx_pkg.sv
// Shared display types and default VGA 640x480 timing for the framebuffer scanout path.
// Provides the colour types and the greyscale palette function used by the reader side.
package gfx_pkg;

    localparam logic [9:0] VGA_H_ACTIVE = 10'd640;
    localparam logic [9:0] VGA_H_FP     = 10'd16;
    localparam logic [9:0] VGA_H_SYNC   = 10'd96;
    localparam logic [9:0] VGA_H_BP     = 10'd48;
    localparam logic [9:0] VGA_V_ACTIVE = 10'd480;
    localparam logic [9:0] VGA_V_FP     = 10'd10;
    localparam logic [9:0] VGA_V_SYNC   = 10'd2;
    localparam logic [9:0] VGA_V_BP     = 10'd33;

    localparam logic [9:0] H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam logic [9:0] V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [3:0] pix_idx_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic rgb444_t default_palette(input pix_idx_t idx);
        rgb444_t c;
        c.r = idx;
        c.g = idx;
        c.b = idx;
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster position counters for the scanout path: raw sync/active flags and the vblank event.
// Counters advance only on pix_ce; geometry is parameterised with VGA 640x480 defaults.
module vga_timing_gen
    import gfx_pkg::*;
#(
    parameter logic [9:0] H_ACTIVE = VGA_H_ACTIVE,
    parameter logic [9:0] H_FP     = VGA_H_FP,
    parameter logic [9:0] H_SYNC   = VGA_H_SYNC,
    parameter logic [9:0] H_BP     = VGA_H_BP,
    parameter logic [9:0] V_ACTIVE = VGA_V_ACTIVE,
    parameter logic [9:0] V_FP     = VGA_V_FP,
    parameter logic [9:0] V_SYNC   = VGA_V_SYNC,
    parameter logic [9:0] V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       pix_ce,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       active_raw,
    output logic       vblank_evt
);

    localparam logic [9:0] H_LAST     = H_ACTIVE + H_FP + H_SYNC + H_BP - 10'd1;
    localparam logic [9:0] V_LAST     = V_ACTIVE + V_FP + V_SYNC + V_BP - 10'd1;
    localparam logic [9:0] H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [9:0] V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (areset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign hs_raw     = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    assign vs_raw     = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    assign active_raw = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);

    // Fires on the tick that moves the raster to (0, V_ACTIVE).
    assign vblank_evt = pix_ce && h_wrap && (v_cnt == V_ACTIVE - 10'd1);

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer reader: VGA timing, raster-order fetch, palette lookup and front/back buffer swap.
// FB_SCANOUT_PALETTE_EN adds a writable 16x12 palette; otherwise the palette is a greyscale ROM.
module fb_scanout
    import gfx_pkg::*;
#(
    parameter logic [9:0] H_ACTIVE = VGA_H_ACTIVE,
    parameter logic [9:0] H_FP     = VGA_H_FP,
    parameter logic [9:0] H_SYNC   = VGA_H_SYNC,
    parameter logic [9:0] H_BP     = VGA_H_BP,
    parameter logic [9:0] V_ACTIVE = VGA_V_ACTIVE,
    parameter logic [9:0] V_FP     = VGA_V_FP,
    parameter logic [9:0] V_SYNC   = VGA_V_SYNC,
    parameter logic [9:0] V_BP     = VGA_V_BP
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        pix_ce,
`ifdef FB_SCANOUT_PALETTE_EN
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [11:0] pal_wdata,
`endif
    output logic        fb_re,
    output logic [9:0]  fb_rd_x,
    output logic [9:0]  fb_rd_y,
    output logic        fb_buf_sel,
    input  logic [3:0]  fb_rdata,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hs_raw;
    logic       vs_raw;
    logic       active_raw;
    logic       vblank_evt;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .areset     (areset),
        .pix_ce     (pix_ce),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .active_raw (active_raw),
        .vblank_evt (vblank_evt)
    );

    pix_idx_t idx_q;
    rgb444_t  pal_rd;
    logic     hs_d, vs_d, act_d;
    logic     hs_q, vs_q, act_q;

    // Sync/active ride a two-stage shadow of the fetch->index pipe so they land with the RGB.
    always_ff @(posedge clk) begin
        if (areset) begin
            fb_re       <= 1'b0;
            fb_rd_x     <= '0;
            fb_rd_y     <= '0;
            idx_q       <= '0;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            act_d       <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            act_q       <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            fb_re <= pix_ce & active_raw;
            if (pix_ce) begin
                fb_rd_x     <= h_cnt;
                fb_rd_y     <= v_cnt;
                hs_d        <= hs_raw;
                vs_d        <= vs_raw;
                act_d       <= active_raw;
                idx_q       <= fb_rdata;
                hs_q        <= hs_d;
                vs_q        <= vs_d;
                act_q       <= act_d;
                vga_hs      <= hs_q;
                vga_vs      <= vs_q;
                vga_blank_n <= act_q;
                vga_r       <= act_q ? pal_rd.r : 4'd0;
                vga_g       <= act_q ? pal_rd.g : 4'd0;
                vga_b       <= act_q ? pal_rd.b : 4'd0;
            end
        end
    end

    // Buffer flip is only ever granted on the vblank tick, so a frame is never torn.
    always_ff @(posedge clk) begin
        if (areset) begin
            fb_buf_sel  <= 1'b0;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
        end else begin
            frame_start <= vblank_evt;
            swap_ack    <= vblank_evt & swap_req;
            if (vblank_evt && swap_req) begin
                fb_buf_sel <= ~fb_buf_sel;
            end
        end
    end

`ifdef FB_SCANOUT_PALETTE_EN
    rgb444_t pal_mem [16];

    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < 16; i++) begin
                pal_mem[i] <= default_palette(pix_idx_t'(i));
            end
        end else if (pal_we) begin
            pal_mem[pal_addr] <= rgb444_t'(pal_wdata);
        end
    end

    assign pal_rd = pal_mem[idx_q];
`else
    assign pal_rd = default_palette(idx_q);
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a reduced-geometry instance for frame-level behaviour plus a
// default 640x480 instance for the real line timing, both against a position-based model.
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        areset;
    logic        pix_ce;
    logic        swap_req;
    logic [3:0]  fb_rdata_i [2];

    logic        fb_re_o  [2];
    logic [9:0]  rx_o     [2];
    logic [9:0]  ry_o     [2];
    logic        buf_o    [2];
    logic        ack_o    [2];
    logic        fs_o     [2];
    logic        hs_o     [2];
    logic        vs_o     [2];
    logic        bl_o     [2];
    logic [3:0]  r_o      [2];
    logic [3:0]  g_o      [2];
    logic [3:0]  b_o      [2];

`ifdef FB_SCANOUT_PALETTE_EN
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_wdata;
`endif

    always #5 clk = ~clk;

    fb_scanout #(
        .H_ACTIVE (10'd16), .H_FP (10'd2), .H_SYNC (10'd4), .H_BP (10'd3),
        .V_ACTIVE (10'd12), .V_FP (10'd2), .V_SYNC (10'd2), .V_BP (10'd3)
    ) dut_s (
        .clk         (clk),
        .areset      (areset),
        .pix_ce      (pix_ce),
`ifdef FB_SCANOUT_PALETTE_EN
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_wdata   (pal_wdata),
`endif
        .fb_re       (fb_re_o[0]),
        .fb_rd_x     (rx_o[0]),
        .fb_rd_y     (ry_o[0]),
        .fb_buf_sel  (buf_o[0]),
        .fb_rdata    (fb_rdata_i[0]),
        .swap_req    (swap_req),
        .swap_ack    (ack_o[0]),
        .frame_start (fs_o[0]),
        .vga_hs      (hs_o[0]),
        .vga_vs      (vs_o[0]),
        .vga_blank_n (bl_o[0]),
        .vga_r       (r_o[0]),
        .vga_g       (g_o[0]),
        .vga_b       (b_o[0])
    );

    fb_scanout dut_f (
        .clk         (clk),
        .areset      (areset),
        .pix_ce      (pix_ce),
`ifdef FB_SCANOUT_PALETTE_EN
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_wdata   (pal_wdata),
`endif
        .fb_re       (fb_re_o[1]),
        .fb_rd_x     (rx_o[1]),
        .fb_rd_y     (ry_o[1]),
        .fb_buf_sel  (buf_o[1]),
        .fb_rdata    (fb_rdata_i[1]),
        .swap_req    (swap_req),
        .swap_ack    (ack_o[1]),
        .frame_start (fs_o[1]),
        .vga_hs      (hs_o[1]),
        .vga_vs      (vs_o[1]),
        .vga_blank_n (bl_o[1]),
        .vga_r       (r_o[1]),
        .vga_g       (g_o[1]),
        .vga_b       (b_o[1])
    );

    // Geometry per instance: [0] reduced, [1] VGA 640x480.
    int HA [2] = '{16, 640};
    int HF [2] = '{2, 16};
    int HS [2] = '{4, 96};
    int HB [2] = '{3, 48};
    int VA [2] = '{12, 480};
    int VF [2] = '{2, 10};
    int VS [2] = '{2, 2};
    int VB [2] = '{3, 33};

    int checks = 0;
    int errors = 0;

    // Reference model: pixel-tick count since reset plus registered expectations.
    int          mk   [2];
    logic        mbuf [2];
    logic        mfs  [2];
    logic        msa  [2];
    logic        mre  [2];
    int          mrx  [2];
    int          mry  [2];
    logic        mhs  [2];
    logic        mvs  [2];
    logic        mbl  [2];
    logic [11:0] mrgb [2];
    logic [11:0] pal_m [16];
    logic [3:0]  fb_tab [64];

    function automatic int htot(int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int vtot(int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    function automatic int hpos(int i, int p);
        return p % htot(i);
    endfunction

    function automatic int vpos(int i, int p);
        return (p / htot(i)) % vtot(i);
    endfunction

    function automatic logic act_at(int i, int p);
        return (hpos(i, p) < HA[i]) && (vpos(i, p) < VA[i]);
    endfunction

    // Framebuffer content: row 0 is an x ramp, the rest is random.
    function automatic logic [3:0] fbfun(int x, int y);
        if (y == 0) return 4'(x);
        return fb_tab[(x * 5 + y * 3) & 63];
    endfunction

    task automatic pal_reset_model();
        for (int j = 0; j < 16; j++) begin
            pal_m[j] = {4'(j), 4'(j), 4'(j)};
        end
    endtask

    task automatic model_edge(int i);
        int p, q, h, v;
        if (areset) begin
            mk[i] = 0; mbuf[i] = 1'b0; mfs[i] = 1'b0; msa[i] = 1'b0; mre[i] = 1'b0;
            mrx[i] = 0; mry[i] = 0; mhs[i] = 1'b1; mvs[i] = 1'b1; mbl[i] = 1'b0;
            mrgb[i] = '0;
        end else begin
            mfs[i] = 1'b0;
            msa[i] = 1'b0;
            mre[i] = 1'b0;
            if (pix_ce) begin
                p = mk[i];
                mrx[i] = hpos(i, p);
                mry[i] = vpos(i, p);
                mre[i] = act_at(i, p);
                mk[i] = p + 1;
                if (hpos(i, mk[i]) == 0 && vpos(i, mk[i]) == VA[i]) begin
                    mfs[i] = 1'b1;
                    if (swap_req) begin
                        msa[i] = 1'b1;
                        mbuf[i] = ~mbuf[i];
                    end
                end
                // Display shows the raster position fetched two ticks ago.
                q = p - 2;
                if (q >= 0) begin
                    h = hpos(i, q);
                    v = vpos(i, q);
                    mhs[i] = !(h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]);
                    mvs[i] = !(v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]);
                    mbl[i] = act_at(i, q);
                    mrgb[i] = mbl[i] ? pal_m[fbfun(h, v)] : 12'h000;
                end
            end
        end
    endtask

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst%0d k=%0d: observed %0h expected %0h", tag, i, mk[i], obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("fb_re",       i, 32'(fb_re_o[i]), 32'(mre[i]));
            chk("fb_rd_x",     i, 32'(rx_o[i]),    32'(mrx[i]));
            chk("fb_rd_y",     i, 32'(ry_o[i]),    32'(mry[i]));
            chk("fb_buf_sel",  i, 32'(buf_o[i]),   32'(mbuf[i]));
            chk("frame_start", i, 32'(fs_o[i]),    32'(mfs[i]));
            chk("swap_ack",    i, 32'(ack_o[i]),   32'(msa[i]));
            chk("vga_hs",      i, 32'(hs_o[i]),    32'(mhs[i]));
            chk("vga_vs",      i, 32'(vs_o[i]),    32'(mvs[i]));
            chk("vga_blank_n", i, 32'(bl_o[i]),    32'(mbl[i]));
            chk("rgb",         i, 32'({r_o[i], g_o[i], b_o[i]}), 32'(mrgb[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
`ifdef FB_SCANOUT_PALETTE_EN
        if (areset) pal_reset_model();
        else if (pal_we) pal_m[pal_addr] = pal_wdata;
`endif
        #1;
        check_all();
        fb_rdata_i[0] = fbfun(int'(rx_o[0]), int'(ry_o[0]));
        fb_rdata_i[1] = fbfun(int'(rx_o[1]), int'(ry_o[1]));
    endtask

    initial begin
        areset = 1'b1;
        pix_ce = 1'b0;
        swap_req = 1'b0;
        fb_rdata_i[0] = '0;
        fb_rdata_i[1] = '0;
`ifdef FB_SCANOUT_PALETTE_EN
        pal_we = 1'b0;
        pal_addr = '0;
        pal_wdata = '0;
`endif
        for (int j = 0; j < 64; j++) fb_tab[j] = 4'($urandom);
        pal_reset_model();

        repeat (3) tick();
        pix_ce = 1'b1;
        tick();
        areset = 1'b0;
        pix_ce = 1'b0;

`ifdef FB_SCANOUT_PALETTE_EN
        pal_we = 1'b1;
        pal_addr = 4'd3;
        pal_wdata = 12'hF00;
        tick();
        pal_we = 1'b0;
`endif

        // pix_ce every second clock, no swap requested: two reduced frames, ~1 VGA line
        for (int n = 0; n < 1900; n++) begin
            pix_ce = (n % 2 == 1);
            tick();
        end

        // held swap request over a whole frame, then released for a frame
        pix_ce = 1'b1;
        swap_req = 1'b1;
        repeat (475) tick();
        swap_req = 1'b0;
        repeat (475) tick();

        // pixel clock stalled mid-line, then resumed
        repeat (8) tick();
        pix_ce = 1'b0;
        repeat (50) tick();
        pix_ce = 1'b1;
        repeat (100) tick();

        // random pix_ce, slowly toggling swap_req, occasional palette writes
        for (int n = 0; n < 3000; n++) begin
            pix_ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) swap_req = ~swap_req;
`ifdef FB_SCANOUT_PALETTE_EN
            pal_we = ($urandom_range(0, 19) == 0);
            pal_addr = 4'($urandom);
            pal_wdata = 12'($urandom);
`endif
            tick();
        end
`ifdef FB_SCANOUT_PALETTE_EN
        pal_we = 1'b0;
`endif

        // make sure a swap has happened, then reset mid-frame with pix_ce active
        pix_ce = 1'b1;
        swap_req = 1'b1;
        repeat (675) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        swap_req = 1'b0;
        for (int n = 0; n < 800; n++) begin
            pix_ce = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 31) == 0) swap_req = ~swap_req;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
